// File: rtl/ram_search_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram_search_arbiter
// Purpose  : Shares one RAM_searcher connection-table engine among NREQ
//            requesters. Picks a requester round-robin, latches its request
//            and tuple, issues a one-cycle command to the searcher, waits for
//            completion or timeout, then returns the result with a one-cycle
//            one-hot acknowledge.
// Ports    : sa_clk/sa_rst        clock, synchronous active-high reset
//            sa_req_* / sa_ip_* / sa_mac_* / sa_port_*
//                                 per-requester request, slice i = requester i
//            sa_ack/sa_error/sa_id_out
//                                 result strobe, code and ID (RESP only)
//            sa_timeouts          saturating count of timed-out searches
//            rs_rq/rs_id_in/rs_*  latched command and tuple to the searcher
//            rs_done/rs_error/rs_id_out
//                                 searcher completion pulse and result
// Revision : 1.0 - initial release
// ============================================================================
module ram_search_arbiter #(
  parameter int         NREQ    = 3,
  parameter int         TIMEOUT = 255,
  parameter logic [7:0] TO_ERR  = 8'hFF
) (
  input  logic                 sa_clk,
  input  logic                 sa_rst,
  input  logic [NREQ-1:0]      sa_req_valid,
  input  logic [2*NREQ-1:0]    sa_req_rq,
  input  logic [8*NREQ-1:0]    sa_req_id,
  input  logic [32*NREQ-1:0]   sa_ip_src,
  input  logic [32*NREQ-1:0]   sa_ip_dst,
  input  logic [24*NREQ-1:0]   sa_mac_src,
  input  logic [24*NREQ-1:0]   sa_mac_dst,
  input  logic [16*NREQ-1:0]   sa_port_src,
  input  logic [16*NREQ-1:0]   sa_port_dst,
  output logic [NREQ-1:0]      sa_ack,
  output logic [7:0]           sa_error,
  output logic [7:0]           sa_id_out,
  output logic [7:0]           sa_timeouts,
  output logic [1:0]           rs_rq,
  output logic [7:0]           rs_id_in,
  output logic [31:0]          rs_ip_src,
  output logic [31:0]          rs_ip_dst,
  output logic [23:0]          rs_mac_src,
  output logic [23:0]          rs_mac_dst,
  output logic [15:0]          rs_port_src,
  output logic [15:0]          rs_port_dst,
  input  logic [7:0]           rs_error,
  input  logic                 rs_done,
  input  logic [7:0]           rs_id_out
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = IW + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]   win_q, win_d;
  logic [15:0]     timer_q, timer_d;
  logic [16:0]     timer_inc;
  logic [1:0]      rq_q, rq_d;
  logic [7:0]      id_q, id_d;
  logic [31:0]     ip_src_q, ip_src_d, ip_dst_q, ip_dst_d;
  logic [23:0]     mac_src_q, mac_src_d, mac_dst_q, mac_dst_d;
  logic [15:0]     port_src_q, port_src_d, port_dst_q, port_dst_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic [7:0]      err_q, err_d;
  logic [7:0]      rid_q, rid_d;
  logic [7:0]      tmo_q, tmo_d;

  logic            grant_any;
  logic [IW-1:0]   grant_idx;
  logic [CW-1:0]   cand;

  // Round-robin pick: first valid requester at or after rr_ptr, wrapping.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = {1'b0, rr_ptr_q} + CW'(i);
      if (cand >= CW'(NREQ)) cand = cand - CW'(NREQ);
      if (!grant_any && sa_req_valid[cand[IW-1:0]]) begin
        grant_any = 1'b1;
        grant_idx = cand[IW-1:0];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    win_d      = win_q;
    timer_d    = timer_q;
    rq_d       = 2'b00;
    id_d       = id_q;
    ip_src_d   = ip_src_q;
    ip_dst_d   = ip_dst_q;
    mac_src_d  = mac_src_q;
    mac_dst_d  = mac_dst_q;
    port_src_d = port_src_q;
    port_dst_d = port_dst_q;
    ack_d      = '0;
    err_d      = 8'h00;
    rid_d      = 8'h00;
    tmo_d      = tmo_q;
    timer_inc  = {1'b0, timer_q} + 17'd1;

    unique case (state_q)
      S_IDLE: begin
        if (grant_any) begin
          win_d      = grant_idx;
          // The command register is loaded on the grant edge so that it is
          // non-zero exactly during the ISSUE cycle.
          rq_d       = sa_req_rq[grant_idx*2 +: 2];
          id_d       = sa_req_id[grant_idx*8 +: 8];
          ip_src_d   = sa_ip_src[grant_idx*32 +: 32];
          ip_dst_d   = sa_ip_dst[grant_idx*32 +: 32];
          mac_src_d  = sa_mac_src[grant_idx*24 +: 24];
          mac_dst_d  = sa_mac_dst[grant_idx*24 +: 24];
          port_src_d = sa_port_src[grant_idx*16 +: 16];
          port_dst_d = sa_port_dst[grant_idx*16 +: 16];
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        timer_d = 16'd0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A completion in the same cycle the timer expires takes priority.
        if (rs_done) begin
          ack_d[win_q] = 1'b1;
          err_d        = rs_error;
          rid_d        = rs_id_out;
          state_d      = S_RESP;
        end else if (timer_inc == 17'(TIMEOUT)) begin
          ack_d[win_q] = 1'b1;
          err_d        = TO_ERR;
          rid_d        = id_q;
          if (tmo_q != 8'hFF) tmo_d = tmo_q + 8'd1;
          state_d      = S_RESP;
        end else begin
          timer_d = timer_inc[15:0];
        end
      end
      S_RESP: begin
        rr_ptr_d = (win_q == IW'(NREQ - 1)) ? '0 : win_q + 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sa_clk) begin
    if (sa_rst) begin
      state_q    <= S_IDLE;
      rr_ptr_q   <= '0;
      win_q      <= '0;
      timer_q    <= 16'd0;
      rq_q       <= 2'b00;
      id_q       <= 8'h00;
      ip_src_q   <= 32'h0;
      ip_dst_q   <= 32'h0;
      mac_src_q  <= 24'h0;
      mac_dst_q  <= 24'h0;
      port_src_q <= 16'h0;
      port_dst_q <= 16'h0;
      ack_q      <= '0;
      err_q      <= 8'h00;
      rid_q      <= 8'h00;
      tmo_q      <= 8'h00;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      win_q      <= win_d;
      timer_q    <= timer_d;
      rq_q       <= rq_d;
      id_q       <= id_d;
      ip_src_q   <= ip_src_d;
      ip_dst_q   <= ip_dst_d;
      mac_src_q  <= mac_src_d;
      mac_dst_q  <= mac_dst_d;
      port_src_q <= port_src_d;
      port_dst_q <= port_dst_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      rid_q      <= rid_d;
      tmo_q      <= tmo_d;
    end
  end

  assign sa_ack      = ack_q;
  assign sa_error    = err_q;
  assign sa_id_out   = rid_q;
  assign sa_timeouts = tmo_q;
  assign rs_rq       = rq_q;
  assign rs_id_in    = id_q;
  assign rs_ip_src   = ip_src_q;
  assign rs_ip_dst   = ip_dst_q;
  assign rs_mac_src  = mac_src_q;
  assign rs_mac_dst  = mac_dst_q;
  assign rs_port_src = port_src_q;
  assign rs_port_dst = port_dst_q;

endmodule
`default_nettype wire

// File: tb/tb_ram_search_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_search_arbiter
// Purpose  : Directed self-checking bench for ram_search_arbiter (NREQ=3,
//            TIMEOUT=16) with hand-computed expected values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_search_arbiter;

  localparam int NREQ = 3;
  localparam int TMO  = 16;

  logic                sa_clk = 1'b0;
  logic                sa_rst;
  logic [NREQ-1:0]     sa_req_valid;
  logic [2*NREQ-1:0]   sa_req_rq;
  logic [8*NREQ-1:0]   sa_req_id;
  logic [32*NREQ-1:0]  sa_ip_src, sa_ip_dst;
  logic [24*NREQ-1:0]  sa_mac_src, sa_mac_dst;
  logic [16*NREQ-1:0]  sa_port_src, sa_port_dst;
  logic [NREQ-1:0]     sa_ack;
  logic [7:0]          sa_error, sa_id_out, sa_timeouts;
  logic [1:0]          rs_rq;
  logic [7:0]          rs_id_in;
  logic [31:0]         rs_ip_src, rs_ip_dst;
  logic [23:0]         rs_mac_src, rs_mac_dst;
  logic [15:0]         rs_port_src, rs_port_dst;
  logic [7:0]          rs_error;
  logic                rs_done;
  logic [7:0]          rs_id_out;

  int checks   = 0;
  int failures = 0;
  bit seen;

  always #5 sa_clk = ~sa_clk;

  ram_search_arbiter #(
    .NREQ    (NREQ),
    .TIMEOUT (TMO),
    .TO_ERR  (8'hFF)
  ) dut (
    .sa_clk       (sa_clk),
    .sa_rst       (sa_rst),
    .sa_req_valid (sa_req_valid),
    .sa_req_rq    (sa_req_rq),
    .sa_req_id    (sa_req_id),
    .sa_ip_src    (sa_ip_src),
    .sa_ip_dst    (sa_ip_dst),
    .sa_mac_src   (sa_mac_src),
    .sa_mac_dst   (sa_mac_dst),
    .sa_port_src  (sa_port_src),
    .sa_port_dst  (sa_port_dst),
    .sa_ack       (sa_ack),
    .sa_error     (sa_error),
    .sa_id_out    (sa_id_out),
    .sa_timeouts  (sa_timeouts),
    .rs_rq        (rs_rq),
    .rs_id_in     (rs_id_in),
    .rs_ip_src    (rs_ip_src),
    .rs_ip_dst    (rs_ip_dst),
    .rs_mac_src   (rs_mac_src),
    .rs_mac_dst   (rs_mac_dst),
    .rs_port_src  (rs_port_src),
    .rs_port_dst  (rs_port_dst),
    .rs_error     (rs_error),
    .rs_done      (rs_done),
    .rs_id_out    (rs_id_out)
  );

  // Advance one clock; inputs are driven and outputs sampled 1 ns after it.
  task automatic tick();
    @(posedge sa_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [1:0] code, input logic [7:0] id);
    sa_req_rq[2*i +: 2] = code;
    sa_req_id[8*i +: 8] = id;
  endtask

  // Called in the rs_rq cycle; pulses rs_done k cycles later and returns in
  // the cycle after the pulse (the expected ack cycle).
  task automatic serve(input int k, input logic [7:0] err, input logic [7:0] id);
    for (int c = 0; c < k; c++) tick();
    rs_done   = 1'b1;
    rs_error  = err;
    rs_id_out = id;
    tick();
    rs_done   = 1'b0;
    rs_error  = 8'h00;
    rs_id_out = 8'h00;
  endtask

  task automatic wait_ack(output bit found);
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      tick();
      if (sa_ack != '0) found = 1'b1;
    end
  endtask

  initial begin
    sa_rst = 1'b1;
    sa_req_valid = '0;
    sa_req_rq = '0;
    sa_req_id = '0;
    rs_done = 1'b0;
    rs_error = 8'h00;
    rs_id_out = 8'h00;
    for (int i = 0; i < NREQ; i++) begin
      sa_ip_src[32*i +: 32]   = 32'hC0A8_0100 + i;
      sa_ip_dst[32*i +: 32]   = 32'h0A00_0200 + i;
      sa_mac_src[24*i +: 24]  = 24'hAA_0000 + i;
      sa_mac_dst[24*i +: 24]  = 24'hBB_0000 + i;
      sa_port_src[16*i +: 16] = 16'h1000 + i;
      sa_port_dst[16*i +: 16] = 16'h2000 + i;
    end
    tick(); tick();
    sa_rst = 1'b0;

    // Reset state
    chk("rst_ack", sa_ack, 0);
    chk("rst_rq", rs_rq, 0);
    chk("rst_id_in", rs_id_in, 0);
    chk("rst_tmo", sa_timeouts, 0);
    chk("rst_err", sa_error, 0);

    // Single lookup from requester 1, searcher answers k=1
    set_req(1, 2'b01, 8'h2A);
    sa_req_valid = 3'b010;
    tick();
    chk("t1_rq", rs_rq, 2'b01);
    chk("t1_id_in", rs_id_in, 8'h2A);
    chk("t1_ip_src", rs_ip_src, 32'hC0A8_0101);
    chk("t1_mac_dst", rs_mac_dst, 24'hBB_0001);
    chk("t1_port_dst", rs_port_dst, 16'h2001);
    chk("t1_ack_early", sa_ack, 0);
    tick();
    chk("t1_rq_cleared", rs_rq, 0);
    chk("t1_ack_wait", sa_ack, 0);
    rs_done = 1'b1; rs_error = 8'h00; rs_id_out = 8'h05;
    tick();
    rs_done = 1'b0; rs_id_out = 8'h00;
    chk("t1_ack", sa_ack, 3'b010);
    chk("t1_id_out", sa_id_out, 8'h05);
    chk("t1_err", sa_error, 8'h00);
    sa_req_valid = 3'b000;
    tick();
    chk("t1_ack_gone", sa_ack, 0);
    chk("t1_idout_gone", sa_id_out, 0);

    // Round robin with all three requesting continuously
    sa_rst = 1'b1;
    tick();
    sa_rst = 1'b0;
    set_req(0, 2'b01, 8'h10);
    set_req(1, 2'b10, 8'h11);
    set_req(2, 2'b11, 8'h12);
    sa_req_valid = 3'b111;
    tick();
    for (int g = 0; g < 6; g++) begin
      chk("rr_id_in", rs_id_in, 8'h10 + (g % 3));
      chk("rr_rq", rs_rq, (g % 3) + 1);
      serve(1, 8'h00, 8'h20 + g);
      chk("rr_ack", sa_ack, 1 << (g % 3));
      chk("rr_id_out", sa_id_out, 8'h20 + g);
      if (g == 5) sa_req_valid = 3'b000;
      tick();
      chk("rr_ack_idle", sa_ack, 0);
      tick();
    end
    chk("rr_no_grant", rs_rq, 0);

    // Timeout from requester 2 (rr_ptr is back at 0)
    set_req(2, 2'b10, 8'h77);
    sa_req_valid = 3'b100;
    tick();
    chk("to_rq", rs_rq, 2'b10);
    for (int c = 0; c < TMO; c++) tick();
    chk("to_ack_early", sa_ack, 0);
    tick();
    chk("to_ack", sa_ack, 3'b100);
    chk("to_err", sa_error, 8'hFF);
    chk("to_id", sa_id_out, 8'h77);
    chk("to_count1", sa_timeouts, 1);

    // Keep requester 2 asserting until 300 timeouts have occurred
    for (int n = 2; n <= 300; n++) begin
      wait_ack(seen);
      chk("sat_ack_seen", seen, 1);
      if (n == 200) chk("sat_count200", sa_timeouts, 200);
    end
    chk("sat_count", sa_timeouts, 255);
    chk("sat_err", sa_error, 8'hFF);
    sa_req_valid = 3'b000;
    tick();

    // Spurious rs_done in IDLE and in ISSUE
    rs_done = 1'b1; rs_id_out = 8'h66;
    tick();
    rs_done = 1'b0;
    chk("sp_idle_ack", sa_ack, 0);
    chk("sp_idle_rq", rs_rq, 0);
    tick();
    chk("sp_idle_ack2", sa_ack, 0);
    set_req(0, 2'b11, 8'h31);
    sa_req_valid = 3'b001;
    tick();
    chk("sp_issue_rq", rs_rq, 2'b11);
    rs_done = 1'b1; rs_id_out = 8'h66;
    tick();
    rs_done = 1'b0; rs_id_out = 8'h00;
    chk("sp_issue_ack", sa_ack, 0);
    tick();
    chk("sp_wait_ack", sa_ack, 0);
    rs_done = 1'b1; rs_error = 8'h03; rs_id_out = 8'h44;
    tick();
    rs_done = 1'b0; rs_error = 8'h00; rs_id_out = 8'h00;
    chk("sp_ack", sa_ack, 3'b001);
    chk("sp_err", sa_error, 8'h03);
    chk("sp_id_out", sa_id_out, 8'h44);

    // Reset asserted mid-WAIT, then a stale rs_done
    set_req(1, 2'b01, 8'h55);
    sa_req_valid = 3'b010;
    tick();
    tick();
    chk("rw_rq", rs_rq, 2'b01);
    tick();
    tick();
    sa_rst = 1'b1;
    sa_req_valid = 3'b000;
    tick();
    sa_rst = 1'b0;
    rs_done = 1'b1; rs_error = 8'h09; rs_id_out = 8'h55;
    tick();
    rs_done = 1'b0; rs_error = 8'h00; rs_id_out = 8'h00;
    chk("rw_ack", sa_ack, 0);
    chk("rw_rq_zero", rs_rq, 0);
    chk("rw_id_in", rs_id_in, 0);
    chk("rw_ip_src", rs_ip_src, 0);
    chk("rw_id_out", sa_id_out, 0);
    chk("rw_tmo", sa_timeouts, 0);
    set_req(0, 2'b01, 8'h60);
    set_req(1, 2'b01, 8'h61);
    set_req(2, 2'b01, 8'h62);
    sa_req_valid = 3'b111;
    tick();
    chk("rw_grant0", rs_id_in, 8'h60);
    serve(2, 8'h00, 8'h70);
    chk("rw_ack0", sa_ack, 3'b001);
    sa_req_valid = 3'b000;
    tick();

    // rs_done lands in the cycle the timer reaches TIMEOUT
    set_req(1, 2'b11, 8'h99);
    sa_req_valid = 3'b010;
    tick();
    chk("tie_rq", rs_rq, 2'b11);
    serve(TMO, 8'h01, 8'hAB);
    chk("tie_ack", sa_ack, 3'b010);
    chk("tie_err", sa_error, 8'h01);
    chk("tie_id", sa_id_out, 8'hAB);
    chk("tie_tmo", sa_timeouts, 0);
    sa_req_valid = 3'b000;
    tick();
    chk("tie_ack_gone", sa_ack, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
